// File: rtl/square_plotter_pkg.sv
// -----------------------------------------------------------------------------
// square_plotter_pkg
//   Shared definitions for the square plotter and its neighbours (the square
//   scheduler uses the same colour and screen constants).
//   Contents:
//     - colour constants, 3-bit {R,G,B}
//     - screen size and last visible column/row
//     - counter width for the in-square column/row counters
//     - FSM state encoding for square_plotter
// -----------------------------------------------------------------------------
package square_plotter_pkg;

   // Colours, {R,G,B}
   localparam logic [2:0] BLACK   = 3'b000;
   localparam logic [2:0] BLUE    = 3'b001;
   localparam logic [2:0] GREEN   = 3'b010;
   localparam logic [2:0] CYAN    = 3'b011;
   localparam logic [2:0] RED     = 3'b100;
   localparam logic [2:0] MAGENTA = 3'b101;
   localparam logic [2:0] YELLOW  = 3'b110;
   localparam logic [2:0] WHITE   = 3'b111;

   // Screen geometry: 160x120 pixels
   localparam int SCREEN_W     = 160;
   localparam int SCREEN_H     = 120;
   localparam int SCREEN_X_MAX = SCREEN_W - 1;
   localparam int SCREEN_Y_MAX = SCREEN_H - 1;

   // Squares are at most 8x8, so 3 bits cover both counters
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/square_plotter_pixel_counter.sv
// -----------------------------------------------------------------------------
// pixel_counter
//   2-D row-major counter used to walk the pixels of one square.
//   cx counts 0..W-1; when it wraps to 0, cy advances 0..H-1 (and wraps).
//   Ports:
//     clk_i    in   clock
//     rst_ni   in   asynchronous active-low reset (counters go to 0)
//     clr_i    in   synchronous clear of both counters (wins over en_i)
//     en_i     in   advance by one pixel
//     cx_o     out  current column offset
//     cy_o     out  current row offset
//     last_o   out  high when the counters sit on the last pixel (W-1,H-1)
// -----------------------------------------------------------------------------
module pixel_counter
   import square_plotter_pkg::*;
#(
   parameter int W = 4,
   parameter int H = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cx_o,
   output logic [CNT_W-1:0] cy_o,
   output logic             last_o
);

   logic [CNT_W-1:0] cx_q, cx_d;
   logic [CNT_W-1:0] cy_q, cy_d;
   logic             cx_last;
   logic             cy_last;

   assign cx_last = (cx_q == CNT_W'(W - 1));
   assign cy_last = (cy_q == CNT_W'(H - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (clr_i) begin
         cx_d = '0;
         cy_d = '0;
      end else if (en_i) begin
         if (cx_last) begin
            cx_d = '0;
            // Wrapping cy too leaves the counter at (0,0) after the last pixel
            cy_d = cy_last ? '0 : cy_q + CNT_W'(1);
         end else begin
            cx_d = cx_q + CNT_W'(1);
         end
      end
   end

   assign cx_o   = cx_q;
   assign cy_o   = cy_q;
   assign last_o = cx_last & cy_last;

endmodule

// File: rtl/square_plotter.sv
// -----------------------------------------------------------------------------
// square_plotter
//   Rasterises one game-board square into SQ_W*SQ_H consecutive VGA pixel
//   writes, one per clock, in row-major order. Black squares are drawn like
//   any other colour; that is how stale notes get erased.
//   Ports:
//     clk         in   system clock
//     resetn      in   asynchronous active-low reset
//     start       in   request to draw a square (ignored while drawing)
//     in_x        in   top-left x of the square
//     in_y        in   top-left y of the square
//     in_colour   in   square colour {R,G,B}
//     vga_x       out  pixel x to the VGA adapter
//     vga_y       out  pixel y to the VGA adapter
//     vga_colour  out  pixel colour to the VGA adapter
//     plot        out  write-enable to the VGA adapter (0 for clipped pixels)
//     busy        out  high while a square is being rasterised
//     done        out  one-cycle pulse after the last pixel slot
//   Handshake: start is a level sampled on posedge clk. It is accepted in
//   IDLE or DONE (back-to-back, no gap) and ignored in DRAW. Acceptance is
//   visible as busy rising on the following cycle; done marks completion.
//   Every output is decoded from registers only.
// -----------------------------------------------------------------------------
module square_plotter
   import square_plotter_pkg::*;
#(
   parameter int SQ_W  = 4,
   parameter int SQ_H  = 4,
   parameter int X_MAX = SCREEN_X_MAX,
   parameter int Y_MAX = SCREEN_Y_MAX
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] in_x,
   input  logic [6:0] in_y,
   input  logic [2:0] in_colour,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   state_e           state_q, state_d;

   logic [7:0]       base_x_q, base_x_d;
   logic [6:0]       base_y_q, base_y_d;
   logic [2:0]       base_colour_q, base_colour_d;

   logic             load;
   logic             cnt_en;
   logic             cnt_last;
   logic [CNT_W-1:0] cx;
   logic [CNT_W-1:0] cy;

   // One bit wider than the port so pixels past the screen edge are seen
   // as out of range instead of wrapping back onto the screen.
   logic [8:0]       x_sum;
   logic [7:0]       y_sum;
   logic             in_range;

   // A new square is accepted from IDLE or DONE only
   assign load   = start & (state_q != ST_DRAW);
   assign cnt_en = (state_q == ST_DRAW);

   pixel_counter #(
      .W (SQ_W),
      .H (SQ_H)
   ) u_pixel_counter (
      .clk_i  (clk),
      .rst_ni (resetn),
      .clr_i  (load),
      .en_i   (cnt_en),
      .cx_o   (cx),
      .cy_o   (cy),
      .last_o (cnt_last)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)    state_d = ST_DRAW;
         ST_DRAW: if (cnt_last) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_DRAW : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- base regs
   always_comb begin
      base_x_d      = base_x_q;
      base_y_d      = base_y_q;
      base_colour_d = base_colour_q;
      if (load) begin
         base_x_d      = in_x;
         base_y_d      = in_y;
         base_colour_d = in_colour;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         base_x_q      <= '0;
         base_y_q      <= '0;
         base_colour_q <= '0;
      end else begin
         base_x_q      <= base_x_d;
         base_y_q      <= base_y_d;
         base_colour_q <= base_colour_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign x_sum    = {1'b0, base_x_q} + {{(9-CNT_W){1'b0}}, cx};
   assign y_sum    = {1'b0, base_y_q} + {{(8-CNT_W){1'b0}}, cy};
   assign in_range = (x_sum <= 9'(X_MAX)) & (y_sum <= 8'(Y_MAX));

   always_comb begin
      vga_x      = x_sum[7:0];
      vga_y      = y_sum[6:0];
      vga_colour = base_colour_q;
      // Clipped pixels still occupy their slot, just without a write
      plot       = (state_q == ST_DRAW) & in_range;
      busy       = (state_q == ST_DRAW);
      done       = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_square_plotter.sv
module tb_square_plotter;
   import square_plotter_pkg::*;

   logic       clk;
   logic       resetn;
   logic       start;
   logic [7:0] in_x;
   logic [6:0] in_y;
   logic [2:0] in_colour;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       plot;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   square_plotter dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_colour  (in_colour),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .plot       (plot),
      .busy       (busy),
      .done       (done)
   );

   // ---------------------------------------------------------------- clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive start with inputs on a negedge, then wait for edge 0.
   task automatic kick(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      @(negedge clk);
      start     = 1'b1;
      in_x      = x;
      in_y      = y;
      in_colour = c;
      @(posedge clk);
   endtask

   task automatic settle;
      repeat (3) @(negedge clk);
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset;
      resetn = 1'b0;
      start = 1'b0; in_x = 8'd0; in_y = 7'd0; in_colour = 3'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({vga_x, vga_y, vga_colour, plot, busy, done} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs got x=%0d y=%0d col=%b plot=%b busy=%b done=%b exp all 0",
                  vga_x, vga_y, vga_colour, plot, busy, done);
      end
      resetn = 1'b1;
      settle();
   endtask

   // (1,53,RED): 16 plots in cycles 1..16, done in cycle 17 only.
   task automatic test_basic;
      int idx;
      logic [7:0] ex;
      logic [6:0] ey;
      kick(8'd1, 7'd53, RED);
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c <= 16) begin
            idx = c - 1;
            ex = 8'(1 + idx % 4);
            ey = 7'(53 + idx / 4);
            checks++;
            if ({vga_x, vga_y, vga_colour, plot, busy, done} !== {ex, ey, 3'b100, 1'b1, 1'b1, 1'b0}) begin
               errors++;
               $display("FAIL basic_pixel c=%0d got x=%0d y=%0d col=%b plot=%b busy=%b done=%b exp x=%0d y=%0d col=100 plot=1 busy=1 done=0",
                        c, vga_x, vga_y, vga_colour, plot, busy, done, ex, ey);
            end
         end else begin
            checks++;
            if ({plot, busy, done} !== {1'b0, 1'b0, (c == 17)}) begin
               errors++;
               $display("FAIL basic_tail c=%0d got plot=%b busy=%b done=%b exp plot=0 busy=0 done=%b",
                        c, plot, busy, done, (c == 17));
            end
         end
      end
      settle();
   endtask

   // start in cycle 5 with other inputs must be ignored.
   task automatic test_start_ignored;
      int idx;
      logic [7:0] ex;
      logic [6:0] ey;
      kick(8'd1, 7'd53, RED);
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (c <= 16) begin
            idx = c - 1;
            ex = 8'(1 + idx % 4);
            ey = 7'(53 + idx / 4);
            checks++;
            if ({vga_x, vga_y, vga_colour, plot, done} !== {ex, ey, 3'b100, 1'b1, 1'b0}) begin
               errors++;
               $display("FAIL ignore_pixel c=%0d got x=%0d y=%0d col=%b plot=%b done=%b exp x=%0d y=%0d col=100 plot=1 done=0",
                        c, vga_x, vga_y, vga_colour, plot, done, ex, ey);
            end
         end else begin
            checks++;
            if ({busy, done} !== {1'b0, (c == 17)}) begin
               errors++;
               $display("FAIL ignore_done c=%0d got busy=%b done=%b exp busy=0 done=%b", c, busy, done, (c == 17));
            end
         end
         // Drive after checking: start high across edge 5 only
         if (c == 1) start = 1'b0;
         if (c == 5) begin
            start = 1'b1; in_x = 8'd40; in_y = 7'd10; in_colour = GREEN;
         end
         if (c == 6) start = 1'b0;
      end
      settle();
   endtask

   // (158,117,CYAN): only x 158..159, y 117..119 plotted.
   task automatic test_clip;
      int idx, ex, ey, n_plot, n_busy;
      logic exp_plot;
      n_plot = 0;
      n_busy = 0;
      kick(8'd158, 7'd117, CYAN);
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (plot === 1'b1) n_plot++;
         if (busy === 1'b1) n_busy++;
         if (c <= 16) begin
            idx = c - 1;
            ex = 158 + idx % 4;
            ey = 117 + idx / 4;
            exp_plot = (ex <= 159) && (ey <= 119);
            checks++;
            if (plot !== exp_plot) begin
               errors++;
               $display("FAIL clip_plot c=%0d got plot=%b exp plot=%b (x=%0d y=%0d)", c, plot, exp_plot, ex, ey);
            end
            if (exp_plot) begin
               checks++;
               if ({vga_x, vga_y, vga_colour} !== {8'(ex), 7'(ey), 3'b011}) begin
                  errors++;
                  $display("FAIL clip_pixel c=%0d got x=%0d y=%0d col=%b exp x=%0d y=%0d col=011",
                           c, vga_x, vga_y, vga_colour, ex, ey);
               end
            end
         end
         if (c == 17) begin
            checks++;
            if (done !== 1'b1) begin
               errors++;
               $display("FAIL clip_done got done=%b exp 1", done);
            end
         end
      end
      checks++;
      if (n_plot != 6) begin
         errors++;
         $display("FAIL clip_count got plots=%0d exp 6", n_plot);
      end
      checks++;
      if (n_busy != 16) begin
         errors++;
         $display("FAIL clip_busy got busy_cycles=%0d exp 16", n_busy);
      end
      settle();
   endtask

   // resetn low in cycle 7 clears outputs without a clock edge.
   task automatic test_reset_mid_draw;
      int n_plot, n_done;
      kick(8'd20, 7'd30, WHITE);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({plot, busy} !== 2'b11) begin
         errors++;
         $display("FAIL rst_pre got plot=%b busy=%b exp plot=1 busy=1", plot, busy);
      end
      #1 resetn = 1'b0;
      #1;
      checks++;
      if ({vga_x, vga_y, vga_colour, plot, busy, done} !== 21'd0) begin
         errors++;
         $display("FAIL rst_async got x=%0d y=%0d col=%b plot=%b busy=%b done=%b exp all 0",
                  vga_x, vga_y, vga_colour, plot, busy, done);
      end
      #1 resetn = 1'b1;
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) n_done++;
      end
      checks++;
      if (n_done != 0) begin
         errors++;
         $display("FAIL rst_no_done got active_cycles=%0d exp 0", n_done);
      end
      n_plot = 0;
      kick(8'd10, 7'd20, BLUE);
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (plot === 1'b1) n_plot++;
         if (c == 1) begin
            checks++;
            if ({vga_x, vga_y, vga_colour} !== {8'd10, 7'd20, 3'b001}) begin
               errors++;
               $display("FAIL rst_redraw_first got x=%0d y=%0d col=%b exp x=10 y=20 col=001",
                        vga_x, vga_y, vga_colour);
            end
         end
         if (c == 17) begin
            checks++;
            if (done !== 1'b1) begin
               errors++;
               $display("FAIL rst_redraw_done got done=%b exp 1", done);
            end
         end
      end
      checks++;
      if (n_plot != 16) begin
         errors++;
         $display("FAIL rst_redraw_count got plots=%0d exp 16", n_plot);
      end
      settle();
   endtask

   // start held in the DONE cycle: second square follows with no gap.
   task automatic test_back_to_back;
      int n_plot;
      n_plot = 0;
      kick(8'd1, 7'd53, RED);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      @(negedge clk);  // cycle 17
      checks++;
      if ({done, busy} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_done got done=%b busy=%b exp done=1 busy=0", done, busy);
      end
      start = 1'b1; in_x = 8'd6; in_y = 7'd53; in_colour = BLACK;
      for (int c = 18; c <= 35; c++) begin
         @(negedge clk);
         if (c == 18) begin
            start = 1'b0;
            checks++;
            if ({vga_x, vga_y, vga_colour, plot, busy} !== {8'd6, 7'd53, 3'b000, 1'b1, 1'b1}) begin
               errors++;
               $display("FAIL b2b_first got x=%0d y=%0d col=%b plot=%b busy=%b exp x=6 y=53 col=000 plot=1 busy=1",
                        vga_x, vga_y, vga_colour, plot, busy);
            end
         end
         if (plot === 1'b1) n_plot++;
         if (c == 33) begin
            checks++;
            if ({vga_x, vga_y, vga_colour, plot} !== {8'd9, 7'd56, 3'b000, 1'b1}) begin
               errors++;
               $display("FAIL b2b_last got x=%0d y=%0d col=%b plot=%b exp x=9 y=56 col=000 plot=1",
                        vga_x, vga_y, vga_colour, plot);
            end
         end
         if (c == 34 || c == 35) begin
            checks++;
            if (done !== (c == 34)) begin
               errors++;
               $display("FAIL b2b_done2 c=%0d got done=%b exp %b", c, done, (c == 34));
            end
         end
      end
      checks++;
      if (n_plot != 16) begin
         errors++;
         $display("FAIL b2b_count got plots=%0d exp 16", n_plot);
      end
      settle();
   endtask

   // (131,75,YELLOW): far-right square, fully on screen.
   task automatic test_far_right;
      int idx, n_plot;
      logic [7:0] ex;
      logic [6:0] ey;
      n_plot = 0;
      kick(8'd131, 7'd75, YELLOW);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         idx = c - 1;
         ex = 8'(131 + idx % 4);
         ey = 7'(75 + idx / 4);
         if (plot === 1'b1) n_plot++;
         checks++;
         if ({vga_x, vga_y, vga_colour, plot} !== {ex, ey, 3'b110, 1'b1}) begin
            errors++;
            $display("FAIL far_pixel c=%0d got x=%0d y=%0d col=%b plot=%b exp x=%0d y=%0d col=110 plot=1",
                     c, vga_x, vga_y, vga_colour, plot, ex, ey);
         end
      end
      checks++;
      if (n_plot != 16) begin
         errors++;
         $display("FAIL far_count got plots=%0d exp 16", n_plot);
      end
      settle();
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      test_reset();
      test_basic();
      test_start_ignored();
      test_clip();
      test_reset_mid_draw();
      test_back_to_back();
      test_far_right();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
